// File: rtl/y86_fde_if.sv
// Bundle of the Y86 fetch/decode/execute stage signals: instruction-memory load port,
// PC/valM inputs, debug register read and all stage results.
interface y86_fde_if;
    logic        imem_we;
    logic [10:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [63:0] PC;
    logic [63:0] valM;
    logic [3:0]  dbg_raddr;
    logic [63:0] dbg_rdata;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        inst_valid;
    logic        imem_er;
    logic        hlt_er;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valE;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cnd;

    modport master (
        output imem_we, imem_waddr, imem_wdata, PC, valM, dbg_raddr,
        input  dbg_rdata, icode, ifun, rA, rB, valC, valP, inst_valid, imem_er, hlt_er,
        input  valA, valB, valE, dstE, dstM, zf, sf, of, cnd
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, PC, valM, dbg_raddr,
        output dbg_rdata, icode, ifun, rA, rB, valC, valP, inst_valid, imem_er, hlt_er,
        output valA, valB, valE, dstE, dstM, zf, sf, of, cnd
    );
endinterface

// File: rtl/y86_fetch_decode_execute.sv
// Single-cycle Y86-64 fetch/decode/execute: 2 KiB byte-wide instruction memory, 15x64 register
// file and condition codes. All outputs are combinational from PC and state; no backpressure.
module y86_fetch_decode_execute (
    input  logic      clk,
    input  logic      reset,
    y86_fde_if.slave  bus
);
    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RSP     = 4'h4;

    logic [7:0]  imem [0:2047];
    logic [63:0] regs [0:14];
    logic        zf_q;
    logic        sf_q;
    logic        of_q;

    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [63:0] last_addr;
    logic [63:0] c_base;
    logic        has_c;
    logic        imem_er;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        inst_valid;
    logic        hlt_er;
    logic        cnd;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valE;
    logic        of_next;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        commit;

    function automatic logic [3:0] inst_len(input logic [3:0] ic);
        case (ic)
            I_CMOV, I_OP, I_PUSH, I_POP:  return 4'd2;
            I_IRMOV, I_RMMOV, I_MRMOV:    return 4'd10;
            I_JXX, I_CALL:                return 4'd9;
            default:                      return 4'd1;
        endcase
    endfunction

    // Bytes beyond the memory read as zero; imem_er masks any use of them.
    function automatic logic [7:0] mem_byte(input logic [63:0] addr);
        return (addr[63:11] == 53'd0) ? imem[addr[10:0]] : 8'h00;
    endfunction

    function automatic logic [63:0] reg_read(input logic [3:0] r);
        return (r == RNONE) ? 64'd0 : regs[r];
    endfunction

    always_comb begin : fetch
        byte0     = mem_byte(bus.PC);
        byte1     = mem_byte(bus.PC + 64'd1);
        last_addr = bus.PC + {60'd0, inst_len(byte0[7:4])} - 64'd1;
        imem_er   = (bus.PC[63:11] != 53'd0) || (last_addr[63:11] != 53'd0);
        icode     = imem_er ? I_NOP : byte0[7:4];
        ifun      = imem_er ? 4'h0  : byte0[3:0];

        rA = RNONE;
        rB = RNONE;
        if (icode inside {I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OP, I_PUSH, I_POP}) begin
            rA = byte1[7:4];
            rB = byte1[3:0];
        end

        has_c  = 1'b0;
        c_base = bus.PC + 64'd2;
        case (icode)
            I_IRMOV, I_RMMOV, I_MRMOV: has_c = 1'b1;
            I_JXX, I_CALL: begin
                has_c  = 1'b1;
                c_base = bus.PC + 64'd1;
            end
            default: ;
        endcase

        // Immediate is stored big-endian: first byte becomes the MSB.
        valC = 64'd0;
        if (has_c) begin
            for (int i = 0; i < 8; i++) begin
                valC = {valC[55:0], mem_byte(c_base + 64'(i))};
            end
        end

        valP = bus.PC + {60'd0, inst_len(icode)};
    end

    always_comb begin : validity
        inst_valid = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_IRMOV, I_RMMOV, I_MRMOV,
            I_CALL, I_RET, I_PUSH, I_POP: inst_valid = (ifun == 4'h0);
            I_CMOV, I_JXX:                inst_valid = (ifun <= 4'h6);
            I_OP:                         inst_valid = (ifun <= 4'h3);
            default:                      inst_valid = 1'b0;
        endcase
        hlt_er = (icode == I_HALT) && !imem_er;
    end

    always_comb begin : condition
        cnd = 1'b0;
        if (icode == I_CMOV || icode == I_JXX) begin
            case (ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (sf_q ^ of_q) | zf_q;
                4'h2:    cnd = sf_q ^ of_q;
                4'h3:    cnd = zf_q;
                4'h4:    cnd = ~zf_q;
                4'h5:    cnd = ~(sf_q ^ of_q);
                4'h6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
                default: cnd = 1'b0;
            endcase
        end
    end

    always_comb begin : decode
        case (icode)
            I_CMOV, I_RMMOV, I_OP, I_PUSH: srcA = rA;
            I_RET, I_POP:                  srcA = RSP;
            default:                       srcA = RNONE;
        endcase
        case (icode)
            I_RMMOV, I_MRMOV, I_OP:         srcB = rB;
            I_CALL, I_RET, I_PUSH, I_POP:   srcB = RSP;
            default:                        srcB = RNONE;
        endcase
        valA = reg_read(srcA);
        valB = reg_read(srcB);

        case (icode)
            I_IRMOV, I_OP:                  dstE = rB;
            I_CMOV:                         dstE = cnd ? rB : RNONE;
            I_CALL, I_RET, I_PUSH, I_POP:   dstE = RSP;
            default:                        dstE = RNONE;
        endcase
        dstM = (icode == I_MRMOV || icode == I_POP) ? rA : RNONE;
    end

    always_comb begin : execute
        valE    = 64'd0;
        of_next = 1'b0;
        case (icode)
            I_CMOV:           valE = valA;
            I_IRMOV:          valE = valC;
            I_RMMOV, I_MRMOV: valE = valB + valC;
            I_CALL, I_PUSH:   valE = valB - 64'd8;
            I_RET, I_POP:     valE = valB + 64'd8;
            I_OP: begin
                case (ifun)
                    4'h0: begin
                        valE    = valB + valA;
                        of_next = (valA[63] == valB[63]) && (valE[63] != valA[63]);
                    end
                    4'h1: begin
                        valE    = valB - valA;
                        of_next = (valA[63] != valB[63]) && (valE[63] != valB[63]);
                    end
                    4'h2:    valE = valB & valA;
                    4'h3:    valE = valB ^ valA;
                    default: valE = 64'd0;
                endcase
            end
            default: valE = 64'd0;
        endcase
    end

    // Faulting, halting or malformed instructions leave architectural state untouched.
    assign commit = inst_valid && !imem_er && !hlt_er;

    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // valM is written after valE so it wins when both target the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= 64'd0;
            end
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (commit) begin
            if (dstE != RNONE) begin
                regs[dstE] <= valE;
            end
            if (dstM != RNONE) begin
                regs[dstM] <= bus.valM;
            end
            if (icode == I_OP) begin
                zf_q <= (valE == 64'd0);
                sf_q <= valE[63];
                of_q <= of_next;
            end
        end
    end

    assign bus.dbg_rdata  = reg_read(bus.dbg_raddr);
    assign bus.icode      = icode;
    assign bus.ifun       = ifun;
    assign bus.rA         = rA;
    assign bus.rB         = rB;
    assign bus.valC       = valC;
    assign bus.valP       = valP;
    assign bus.inst_valid = inst_valid;
    assign bus.imem_er    = imem_er;
    assign bus.hlt_er     = hlt_er;
    assign bus.valA       = valA;
    assign bus.valB       = valB;
    assign bus.valE       = valE;
    assign bus.dstE       = dstE;
    assign bus.dstM       = dstM;
    assign bus.zf         = zf_q;
    assign bus.sf         = sf_q;
    assign bus.of         = of_q;
    assign bus.cnd        = cnd;
endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
// Bench for y86_fetch_decode_execute: directed program vectors, corner sequences and
// randomized instructions checked against an instruction-level reference model.
module tb_y86_fetch_decode_execute;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    y86_fde_if bus ();
    y86_fetch_decode_execute dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [63:0] FAR_PC = 64'h0000_0001_0000_0000;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_mem [0:2047];
    logic [63:0] m_reg [0:14];
    logic        m_zf, m_sf, m_of;

    typedef struct packed {
        logic [3:0]  icode, ifun, rA, rB;
        logic [63:0] valC, valP;
        logic        valid, er, hlt;
        logic [63:0] valA, valB, valE;
        logic [3:0]  dstE, dstM;
        logic        cnd;
        logic [63:0] dbg;
    } exp_t;

    typedef struct {
        logic [79:0] code;
        int          nb;
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [63:0] valp;
        logic [63:0] vale;
        logic [3:0]  dste;
        logic        cnd;
        logic        hlt;
        logic        valid;
        logic        er;
        logic [3:0]  chk_reg;
        logic [63:0] reg_val;
        logic        zf_after;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input logic [63:0] a);
        if (a < 64'd2048) return m_mem[a[10:0]];
        return 8'h00;
    endfunction

    function automatic logic [63:0] rval(input logic [3:0] r);
        if (r == 4'hF) return 64'd0;
        return m_reg[r];
    endfunction

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            4'h7, 4'h8:             return 9;
            default:                return 1;
        endcase
    endfunction

    function automatic exp_t predict(input logic [63:0] pc, input logic [3:0] dbg);
        exp_t        e;
        logic [7:0]  b0, b1;
        logic [3:0]  sa, sb;
        logic [63:0] end_addr;
        int          coff;
        e        = '0;
        b0       = mbyte(pc);
        end_addr = pc + 64'(ilen(b0[7:4])) - 64'd1;
        e.er     = (pc > 64'd2047) || (end_addr > 64'd2047);
        e.icode  = e.er ? 4'h1 : b0[7:4];
        e.ifun   = e.er ? 4'h0 : b0[3:0];
        b1       = mbyte(pc + 64'd1);
        {e.rA, e.rB} = (e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? b1 : 8'hFF;
        coff = (e.icode inside {4'h3, 4'h4, 4'h5}) ? 2 : (e.icode inside {4'h7, 4'h8}) ? 1 : 0;
        if (coff != 0)
            for (int k = 0; k < 8; k++) e.valC = (e.valC << 8) | 64'(mbyte(pc + 64'(coff + k)));
        e.valP = pc + 64'(ilen(e.icode));
        case (e.icode)
            4'h2, 4'h7: e.valid = (e.ifun <= 4'h6);
            4'h6:       e.valid = (e.ifun <= 4'h3);
            4'hC, 4'hD, 4'hE, 4'hF: e.valid = 1'b0;
            default:    e.valid = (e.ifun == 4'h0);
        endcase
        e.hlt = (e.icode == 4'h0) && !e.er;
        if (e.icode == 4'h2 || e.icode == 4'h7) begin
            case (e.ifun)
                4'h0: e.cnd = 1'b1;
                4'h1: e.cnd = (m_sf ^ m_of) | m_zf;
                4'h2: e.cnd = m_sf ^ m_of;
                4'h3: e.cnd = m_zf;
                4'h4: e.cnd = !m_zf;
                4'h5: e.cnd = !(m_sf ^ m_of);
                4'h6: e.cnd = !(m_sf ^ m_of) && !m_zf;
                default: e.cnd = 1'b0;
            endcase
        end
        sa = (e.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? e.rA :
             (e.icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        sb = (e.icode inside {4'h4, 4'h5, 4'h6}) ? e.rB :
             (e.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        e.valA = rval(sa);
        e.valB = rval(sb);
        case (e.icode)
            4'h2:       e.valE = e.valA;
            4'h3:       e.valE = e.valC;
            4'h4, 4'h5: e.valE = e.valB + e.valC;
            4'h8, 4'hA: e.valE = e.valB - 64'd8;
            4'h9, 4'hB: e.valE = e.valB + 64'd8;
            4'h6: case (e.ifun)
                4'h0: e.valE = e.valB + e.valA;
                4'h1: e.valE = e.valB - e.valA;
                4'h2: e.valE = e.valB & e.valA;
                4'h3: e.valE = e.valB ^ e.valA;
                default: e.valE = 64'd0;
            endcase
            default: e.valE = 64'd0;
        endcase
        e.dstE = (e.icode inside {4'h3, 4'h6}) ? e.rB :
                 (e.icode == 4'h2) ? (e.cnd ? e.rB : 4'hF) :
                 (e.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        e.dstM = (e.icode inside {4'h5, 4'hB}) ? e.rA : 4'hF;
        e.dbg  = rval(dbg);
        return e;
    endfunction

    // Overflow as true signed overflow: the 65-bit sign-extended result disagrees in its top two bits.
    function automatic logic signed_ovf(input logic [63:0] a, input logic [63:0] b, input logic fn);
        logic [64:0] r;
        r = fn ? ({b[63], b} - {a[63], a}) : ({b[63], b} + {a[63], a});
        return r[64] ^ r[63];
    endfunction

    task automatic tick();
        exp_t e;
        e = predict(bus.PC, bus.dbg_raddr);
        if (reset) begin
            for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        end else if (e.valid && !e.er && !e.hlt) begin
            if (e.dstE != 4'hF) m_reg[e.dstE] = e.valE;
            if (e.dstM != 4'hF) m_reg[e.dstM] = bus.valM;
            if (e.icode == 4'h6) begin
                m_zf = (e.valE == 64'd0);
                m_sf = e.valE[63];
                m_of = (e.ifun <= 4'h1) ? signed_ovf(e.valA, e.valB, e.ifun[0]) : 1'b0;
            end
        end
        if (bus.imem_we) m_mem[bus.imem_waddr] = bus.imem_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [10:0] a, input logic [7:0] d);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = a;
        bus.imem_wdata = d;
        tick();
        bus.imem_we    = 1'b0;
    endtask

    task automatic compare_all(input exp_t e, input string tag);
        check({tag, ".icode"}, 64'(bus.icode), 64'(e.icode));
        check({tag, ".ifun"},  64'(bus.ifun),  64'(e.ifun));
        check({tag, ".rA"},    64'(bus.rA),    64'(e.rA));
        check({tag, ".rB"},    64'(bus.rB),    64'(e.rB));
        check({tag, ".valC"},  bus.valC,       e.valC);
        check({tag, ".valP"},  bus.valP,       e.valP);
        check({tag, ".valid"}, 64'(bus.inst_valid), 64'(e.valid));
        check({tag, ".imem_er"}, 64'(bus.imem_er), 64'(e.er));
        check({tag, ".hlt_er"},  64'(bus.hlt_er),  64'(e.hlt));
        check({tag, ".valA"},  bus.valA,       e.valA);
        check({tag, ".valB"},  bus.valB,       e.valB);
        check({tag, ".valE"},  bus.valE,       e.valE);
        check({tag, ".dstE"},  64'(bus.dstE),  64'(e.dstE));
        check({tag, ".dstM"},  64'(bus.dstM),  64'(e.dstM));
        check({tag, ".cnd"},   64'(bus.cnd),   64'(e.cnd));
        check({tag, ".dbg"},   bus.dbg_rdata,  e.dbg);
        check({tag, ".cc"},    64'({bus.zf, bus.sf, bus.of}), 64'({m_zf, m_sf, m_of}));
    endtask

    task automatic load_code(input logic [79:0] code, input int nb, input int base);
        logic [79:0] c;
        c = code;
        bus.PC = FAR_PC;
        for (int k = 0; k < nb; k++) begin
            if (base + k < 2048) wr_byte(11'(base + k), c[79 - 8 * k -: 8]);
        end
    endtask

    task automatic dbg_check(input string name, input logic [3:0] r, input logic [63:0] exp);
        bus.dbg_raddr = r;
        #1;
        check(name, bus.dbg_rdata, exp);
    endtask

    initial begin
        logic [79:0] code;
        logic [3:0]  ic, fn;
        int          sel, base;

        vecs[0] = '{{8'h30, 8'hF0, 64'h4},  10, 64'd0,    4'h3, 64'd10, 64'd4,  4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 64'd4,  1'b1};
        vecs[1] = '{{8'h30, 8'hF3, 64'hA},  10, 64'd10,   4'h3, 64'd20, 64'd10, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 64'd10, 1'b1};
        vecs[2] = '{{8'h60, 8'h03, 64'h0},  2,  64'd20,   4'h6, 64'd22, 64'd14, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 64'd14, 1'b0};
        vecs[3] = '{{8'h61, 8'h33, 64'h0},  2,  64'd22,   4'h6, 64'd24, 64'd0,  4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 64'd0,  1'b1};
        vecs[4] = '{{8'h73, 64'h0, 8'h00},  9,  64'd24,   4'h7, 64'd33, 64'd0,  4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 64'd0,  1'b1};
        vecs[5] = '{{8'h24, 8'h01, 64'h0},  2,  64'd33,   4'h2, 64'd35, 64'd4,  4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 64'd0,  1'b1};
        vecs[6] = '{{8'h00, 72'h0},         1,  64'd35,   4'h0, 64'd36, 64'd0,  4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 64'd4,  1'b1};
        vecs[7] = '{{8'hC0, 72'h0},         1,  64'd36,   4'hC, 64'd37, 64'd0,  4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 64'd4,  1'b1};
        vecs[8] = '{{8'h30, 8'hF0, 64'h0},  8,  64'd2040, 4'h1, 64'd0,  64'd0,  4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 64'd4,  1'b1};

        reset = 1'b1;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
        bus.PC = FAR_PC; bus.valM = '0; bus.dbg_raddr = '0;
        for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;

        // Memory is filled with nops while reset is held, so every later fetch is defined.
        for (int a = 0; a < 2048; a++) begin
            m_mem[a] = 8'h10;
            wr_byte(11'(a), 8'h10);
        end
        reset = 1'b0;

        for (int r = 0; r < 16; r++) dbg_check("reset_reg", 4'(r), 64'd0);
        check("reset_cc", 64'({bus.zf, bus.sf, bus.of}), 64'(3'b100));

        foreach (vecs[i]) begin
            load_code(vecs[i].code, vecs[i].nb, int'(vecs[i].pc));
            bus.PC = vecs[i].pc;
            bus.dbg_raddr = 4'h0;
            #1;
            check("vec_icode", 64'(bus.icode), 64'(vecs[i].icode));
            if (vecs[i].valid && !vecs[i].er) check("vec_valP", bus.valP, vecs[i].valp);
            check("vec_valE",  bus.valE,        vecs[i].vale);
            check("vec_dstE",  64'(bus.dstE),   64'(vecs[i].dste));
            check("vec_cnd",   64'(bus.cnd),    64'(vecs[i].cnd));
            check("vec_hlt",   64'(bus.hlt_er), 64'(vecs[i].hlt));
            check("vec_valid", 64'(bus.inst_valid), 64'(vecs[i].valid));
            check("vec_imem_er", 64'(bus.imem_er), 64'(vecs[i].er));
            compare_all(predict(bus.PC, bus.dbg_raddr), "vec_model");
            tick();
            dbg_check("vec_reg_after", vecs[i].chk_reg, vecs[i].reg_val);
            check("vec_zf_after", 64'(bus.zf), 64'(vecs[i].zf_after));
        end

        // popq into %rsp: both write ports hit register 4 and the loaded value must win.
        load_code({8'hB0, 8'h4F, 64'h0}, 2, 40);
        bus.PC = 64'd40;
        bus.valM = 64'h1234;
        #1;
        check("pop_dstE", 64'(bus.dstE), 64'h4);
        check("pop_dstM", 64'(bus.dstM), 64'h4);
        check("pop_valE", bus.valE, 64'd8);
        tick();
        dbg_check("pop_rsp", 4'h4, 64'h1234);

        // Fetch during a write to the same byte sees the old contents until the edge.
        bus.PC = 64'd60;
        bus.imem_we = 1'b1; bus.imem_waddr = 11'd60; bus.imem_wdata = 8'h00;
        #1;
        check("wr_old_icode", 64'(bus.icode), 64'h1);
        tick();
        bus.imem_we = 1'b0;
        #1;
        check("wr_new_icode", 64'(bus.icode), 64'h0);
        check("wr_new_hlt", 64'(bus.hlt_er), 64'h1);

        // Reset mid-program beats the irmovq at PC=0; a memory write in the reset cycle still lands.
        bus.PC = 64'd0;
        reset = 1'b1;
        bus.imem_we = 1'b1; bus.imem_waddr = 11'd50; bus.imem_wdata = 8'h90;
        tick();
        reset = 1'b0;
        bus.imem_we = 1'b0;
        dbg_check("rst_reg0", 4'h0, 64'd0);
        dbg_check("rst_reg3", 4'h3, 64'd0);
        dbg_check("rst_reg4", 4'h4, 64'd0);
        check("rst_zf", 64'(bus.zf), 64'h1);
        check("rst_keep_icode", 64'(bus.icode), 64'h3);
        check("rst_keep_valC", bus.valC, 64'd4);
        bus.PC = 64'd50;
        #1;
        check("rst_write_icode", 64'(bus.icode), 64'h9);

        for (int it = 0; it < 250; it++) begin
            code[31:0]  = $urandom;
            code[63:32] = $urandom;
            code[79:64] = 16'($urandom);
            sel = $urandom_range(0, 9);
            ic  = (sel < 4) ? 4'h6 : (sel == 4) ? 4'h2 : (sel == 5) ? 4'h7 :
                  (sel == 6) ? 4'h3 : 4'($urandom_range(0, 15));
            if (ic == 4'h6) fn = 4'($urandom_range(0, 4));
            else            fn = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 7));
            code[79:72] = {ic, fn};
            base = ($urandom_range(0, 7) == 0) ? $urandom_range(2030, 2047) : $urandom_range(0, 2037);
            load_code(code, 10, base);
            if ($urandom_range(0, 19) == 0) bus.PC = FAR_PC | {32'($urandom), 32'($urandom)};
            else                            bus.PC = 64'(base);
            bus.valM      = {32'($urandom), 32'($urandom)};
            bus.dbg_raddr = 4'($urandom_range(0, 15));
            #1;
            compare_all(predict(bus.PC, bus.dbg_raddr), "rnd");
            reset = ($urandom_range(0, 39) == 0);
            tick();
            reset = 1'b0;
            check("rnd_cc_after", 64'({bus.zf, bus.sf, bus.of}), 64'({m_zf, m_sf, m_of}));
            check("rnd_dbg_after", bus.dbg_rdata, rval(bus.dbg_raddr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/y86_fetch_decode_execute.md
Y86_FETCH_DECODE_EXECUTE -- requirements
Module: y86_fetch_decode_execute

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: imem_we in 1, imem_waddr in 11, imem_wdata in 8  byte write into 2048-byte instruction memory.
REQ-004 SHALL have port: PC  in  64  address of the current instruction.
REQ-005 SHALL have port: valM  in  64  memory-stage result, written to dstM.
REQ-006 SHALL have ports: dbg_raddr in 4, dbg_rdata out 64  combinational register-file read; 0 when dbg_raddr=0xF.
REQ-007 SHALL have outputs: icode 4, ifun 4, rA 4, rB 4, valC 64, valP 64.
REQ-008 SHALL have outputs: inst_valid 1, imem_er 1, hlt_er 1.
REQ-009 SHALL have outputs: valA 64, valB 64, valE 64, dstE 4, dstM 4.
REQ-010 SHALL have outputs: zf 1, sf 1, of 1 (registered condition codes), and cnd 1.

Function
REQ-011 Fetch SHALL be combinational from PC: byte0={icode,ifun}; byte1={rA,rB} for icodes 2-6, A and B, else rA=rB=0xF.
REQ-012 valC SHALL be 8 bytes, big-endian: the first valC byte is the MSB. valC starts at PC+2 for icodes 3-5 and at PC+1 for icodes 7-8. For all other icodes valC=0.
REQ-013 valP SHALL be PC+1 for icodes 0, 1 and 9. It SHALL be PC+2 for 2, 6, A and B; PC+10 for 3-5; PC+9 for 7-8. All additions are 64-bit and wrap.
REQ-014 imem_er SHALL be 1 when any byte of the instruction (PC .. valP-1) is above address 2047. In that case icode/ifun SHALL read 1/0 (nop) and valC=0.
REQ-015 inst_valid SHALL be 1 only for valid encodings:
- icode 0-1, 3-5, 8-9, A-B with ifun=0;
- icode 2 and 7 with ifun 0-6;
- icode 6 with ifun 0-3.
REQ-016 hlt_er SHALL be 1 when icode=0 and imem_er=0.
REQ-017 srcA SHALL be rA for icodes 2, 4, 6 and A; 4 (RSP) for 9 and B; else 0xF. valA SHALL be reg[srcA], or 0 when srcA=0xF.
REQ-018 srcB SHALL be rB for icodes 4-6; 4 for icodes 8, 9, A and B; else 0xF. valB SHALL be reg[srcB], or 0 when srcB=0xF.
REQ-019 dstE SHALL be rB for icode 3 and 6, and for icode 2 when cnd=1; 4 for icodes 8, 9, A and B; else 0xF. dstM SHALL be rA for icodes 5 and B; else 0xF.
REQ-020 valE SHALL be computed per icode:
- 2: valA;
- 3: valC;
- 4-5: valB+valC;
- 7: 0;
- 8 and A: valB-8;
- 9 and B: valB+8;
- 6: valB op valA, where op is add, sub (valB-valA), and or xor for ifun 0, 1, 2, 3.
REQ-021 For OPq, overflow SHALL be computed as follows. add: of = (valA[63]==valB[63]) & (valE[63]!=valA[63]). sub: of = (valA[63]!=valB[63]) & (valE[63]!=valB[63]). and/xor: of = 0.
REQ-022 CC SHALL update at posedge only for icode 6: zf=(valE==0), sf=valE[63], of per REQ-021.
REQ-023 cnd SHALL be combinational from the registered CC, for icodes 2 and 7 only (cnd=0 for all other icodes):
- ifun 0: always 1;
- ifun 1 (le): (sf^of)|zf;
- ifun 2 (l): sf^of;
- ifun 3 (e): zf;
- ifun 4 (ne): ~zf;
- ifun 5 (ge): ~(sf^of);
- ifun 6 (g): ~(sf^of)&~zf.
REQ-024 Register file SHALL hold 15 x 64 bits (0-14). At posedge it SHALL write valE to dstE and valM to dstM when each is not 0xF. When dstE==dstM, valM wins.
REQ-025 Register writes and CC updates SHALL be suppressed in the cycle when inst_valid=0, imem_er=1 or hlt_er=1.
REQ-026 Instruction-memory writes SHALL occur at posedge whenever imem_we=1, including during reset. Same-cycle fetch of that byte SHALL see the old value.
REQ-027 All outputs other than CC SHALL be combinational (zero-cycle latency from PC/state). State changes SHALL be visible the cycle after the edge.

Reset
REQ-028 With reset=1 at posedge: all 15 registers SHALL be cleared to 0, and CC SHALL be set to zf=1, sf=0, of=0.
REQ-029 Reset SHALL have priority over register/CC writes. Instruction memory SHALL NOT be cleared by reset.
REQ-030 Instruction memory content SHALL be undefined until written.

Verification
REQ-031 Load bytes 30 F0 00 00 00 00 00 00 00 04 at address 0, PC=0 -> icode=3, rB=0, valC=4, valP=10, valE=4, dstE=0. After the edge, reg0=4.
REQ-032 Load 30 F3 00..00 0A at address 10, PC=10 -> valC=10, valP=20. After the edge, reg3=10.
REQ-033 Load 60 03 at address 20, PC=20 with reg0=4, reg3=10 -> valA=4, valB=10, valE=14, valP=22. After the edge: reg3=14, zf=0, sf=0, of=0.
REQ-034 Execute subq 61 33 with reg3=14 -> valE=0; after the edge zf=1. Then 73 (je) at the next PC -> cnd=1. Then 24 (cmovne) -> cnd=0, dstE=0xF, no register write.
REQ-035 Byte 00 at PC -> hlt_er=1, valP=PC+1, no writes. Byte C0 -> inst_valid=0, no writes.
REQ-036 irmovq at PC=2040 -> imem_er=1 and no writes. Assert reset mid-program -> all registers read 0, zf=1, and instruction memory is retained.
